// File: rtl/mm_requant.sv
// ---- mm_requant : bias + dyadic-scale requantizer, 4-stage AXI-stream pipeline ----
// ---- Rev 1.0 ----
`default_nettype none

module mm_requant #(
  parameter  int D_W          = 8,
  parameter  int D_W_ACC      = 32,
  parameter  int MULT_W       = 32,
  parameter  int SHIFT_W      = 6,
  parameter  int MATRIXSIZE_W = 24,
  parameter  int MAX_COLS     = 1024,
  localparam int ADDR_W_C     = $clog2(MAX_COLS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [D_W_ACC-1:0]      s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  output logic [D_W-1:0]          m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  input  logic [MATRIXSIZE_W-1:0] M3,
  input  logic [MULT_W-1:0]       MULT,
  input  logic [SHIFT_W-1:0]      SHIFT,
  input  logic                    cfg_we,
  input  logic [ADDR_W_C-1:0]     cfg_addr,
  input  logic [D_W_ACC-1:0]      cfg_bias,
  output logic                    busy,
  output logic [31:0]             sat_count
);

  localparam int SUM_W  = D_W_ACC + 1;
  localparam int PROD_W = D_W_ACC + MULT_W + 2;
  localparam int RND_W  = PROD_W + 1;

  localparam logic signed [RND_W-1:0] C_MAX = RND_W'((2 ** (D_W - 1)) - 1);
  localparam logic signed [RND_W-1:0] C_MIN = ~C_MAX;

  logic signed [D_W_ACC-1:0] bias_mem [MAX_COLS];
  logic signed [D_W_ACC-1:0] bias_q;
  logic [ADDR_W_C-1:0]       col;

  logic                      en;
  logic                      accept;
  logic                      col_wrap;
  logic                      v0, v1, v2;
  logic                      l0, l1, l2;
  logic signed [D_W_ACC-1:0] acc0;
  logic signed [SUM_W-1:0]   sum1;
  logic signed [PROD_W-1:0]  prod2;

  logic signed [SUM_W-1:0]   sum_w;
  logic signed [PROD_W-1:0]  prod_w;
  logic signed [PROD_W-1:0]  mult_s;
  logic signed [RND_W-1:0]   half_w;
  logic signed [RND_W-1:0]   rnd_w;
  logic                      clip_w;
  logic [D_W-1:0]            q_w;

  assign en       = ~m_tvalid | m_tready;
  assign s_tready = en;
  assign accept   = s_tvalid & en;
  assign busy     = v0 | v1 | v2 | m_tvalid;
  assign col_wrap = (MATRIXSIZE_W'(col) == (M3 - MATRIXSIZE_W'(1)));

  // Bias table has no reset; writes are only honoured while the pipeline is empty.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) bias_mem[cfg_addr] <= cfg_bias;
    if (en) bias_q <= bias_mem[col];
  end

  always_comb begin
    sum_w  = SUM_W'(acc0) + SUM_W'(bias_q);
    mult_s = $signed({{(PROD_W - MULT_W){1'b0}}, MULT});
    prod_w = PROD_W'(sum1) * mult_s;
    half_w = $signed(RND_W'(1) << (SHIFT - SHIFT_W'(1)));
    rnd_w  = RND_W'(prod2);
    if (SHIFT != '0) rnd_w = (rnd_w + half_w) >>> SHIFT;
    clip_w = (rnd_w > C_MAX) || (rnd_w < C_MIN);
    q_w    = rnd_w[D_W-1:0];
    if (rnd_w > C_MAX) q_w = {1'b0, {(D_W - 1){1'b1}}};
    if (rnd_w < C_MIN) q_w = {1'b1, {(D_W - 1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      l0        <= 1'b0;
      l1        <= 1'b0;
      l2        <= 1'b0;
      acc0      <= '0;
      sum1      <= '0;
      prod2     <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      m_tdata   <= '0;
      sat_count <= '0;
    end else begin
      if (accept) col <= (s_tlast || col_wrap) ? '0 : col + ADDR_W_C'(1);
      if (en) begin
        v0       <= s_tvalid;
        l0       <= s_tlast;
        acc0     <= s_tdata;
        v1       <= v0;
        l1       <= l0;
        sum1     <= sum_w;
        v2       <= v1;
        l2       <= l1;
        prod2    <= prod_w;
        m_tvalid <= v2;
        m_tlast  <= l2;
        m_tdata  <= q_w;
        if (v2 && clip_w && (sat_count != '1)) sat_count <= sat_count + 32'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mm_requant.sv
// ---- tb_mm_requant : directed table + randomized reference-model bench for mm_requant ----
// ---- Rev 1.0 ----
`default_nettype none

module tb_mm_requant;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [23:0] M3;
  logic [31:0] MULT;
  logic [5:0]  SHIFT;
  logic        cfg_we;
  logic [9:0]  cfg_addr;
  logic [31:0] cfg_bias;
  logic        busy;
  logic [31:0] sat_count;

  mm_requant dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .M3(M3), .MULT(MULT), .SHIFT(SHIFT),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bias(cfg_bias),
    .busy(busy), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          m3;
    logic [31:0] mult;
    int          shift;
    logic [31:0] b0;
    logic [31:0] acc;
    bit          last;
    logic [7:0]  exp;
    bit          explast;
    int          clip;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    bit         l;
  } exp_t;

  exp_t               expq[$];
  logic signed [31:0] sh_bias [8];
  int                 n_vec = 0;
  int                 n_err = 0;
  int                 mcol = 0;
  int                 exp_sat = 0;
  int                 cur_m3;
  logic [31:0]        cur_mult;
  int                 cur_shift;
  bit                 rand_ready = 0;
  bit                 mon_en = 0;
  bit                 last_acc;
  bit                 held = 0;
  logic [7:0]         hd;
  logic               hl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output checker: scoreboard pop on every handshake, and hold check after every stall.
  task automatic mon();
    exp_t e;
    if (mon_en) begin
      if (held) begin
        chk("hold_valid", 64'(m_tvalid), 64'd1);
        chk("hold_data", 64'(m_tdata), 64'(hd));
        chk("hold_last", 64'(m_tlast), 64'(hl));
      end
      if (m_tvalid && m_tready) begin
        if (expq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %0h expected none at %0t", m_tdata, $time);
        end else begin
          e = expq.pop_front();
          chk("data", 64'(m_tdata), 64'(e.d));
          chk("last", 64'(m_tlast), 64'(e.l));
        end
      end
      held = m_tvalid && !m_tready;
      hd   = m_tdata;
      hl   = m_tlast;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    last_acc = s_tvalid && s_tready;
    @(posedge clk);
    #1;
    if (rand_ready) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] acc, input bit last, input logic [7:0] e, input bit el);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = acc;
    s_tlast  = last;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 200);
    s_tvalid = 1'b0;
    if (!last_acc) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got no accept expected accept at %0t", $time);
    end else begin
      expq.push_back('{e, el});
      mcol = (last || mcol == cur_m3 - 1) ? 0 : mcol + 1;
    end
  endtask

  // Reference: exact wide arithmetic, floor((x + 2^(s-1)) / 2^s), then clip.
  function automatic logic [7:0] ref_q(input logic signed [31:0] acc, input logic signed [31:0] b,
                                       output bit clip);
    logic signed [127:0] a, bb, v, m;
    a  = acc;
    bb = b;
    m  = {96'b0, cur_mult};
    v  = (a + bb) * m;
    if (cur_shift > 0) v = (v + (128'sd1 <<< (cur_shift - 1))) >>> cur_shift;
    clip = (v > 127) || (v < -128);
    if (v > 127) return 8'h7f;
    if (v < -128) return 8'h80;
    return v[7:0];
  endfunction

  task automatic send_model(input logic [31:0] acc, input bit last);
    bit c;
    logic [7:0] e;
    e = ref_q(acc, sh_bias[mcol], c);
    if (c) exp_sat++;
    send(acc, last, e, last);
  endtask

  task automatic wr(input int addr, input logic [31:0] val, input bit taken);
    cfg_we   = 1'b1;
    cfg_addr = 10'(addr);
    cfg_bias = val;
    tick();
    cfg_we = 1'b0;
    if (taken) sh_bias[addr] = val;
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || busy) && n < 500) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(expq.size() != 0 || busy), 64'd0);
    chk("sat_count", 64'(sat_count), 64'(exp_sat));
  endtask

  task automatic set_cfg(input int m3, input logic [31:0] mult, input int sh);
    cur_m3 = m3; cur_mult = mult; cur_shift = sh;
    M3 = 24'(m3); MULT = mult; SHIFT = 6'(sh);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[13];
    tbl[0]  = '{1, 32'd1, 4, 32'd0, -32'sd40, 1'b0, 8'hfe, 1'b0, 0};
    tbl[1]  = '{1, 32'd1, 4, 32'd0, -32'sd24, 1'b0, 8'hff, 1'b0, 0};
    tbl[2]  = '{1, 32'd1, 4, 32'd0, 32'd40, 1'b0, 8'h03, 1'b0, 0};
    tbl[3]  = '{1, 32'd1, 0, 32'd0, 32'd200, 1'b0, 8'h7f, 1'b0, 1};
    tbl[4]  = '{1, 32'd1, 0, 32'd0, -32'sd129, 1'b0, 8'h80, 1'b0, 1};
    tbl[5]  = '{1, 32'd1, 0, 32'd0, 32'h7fffffff, 1'b0, 8'h7f, 1'b0, 1};
    tbl[6]  = '{3, 32'd1, 0, 32'd1, 32'd0, 1'b0, 8'd1, 1'b0, 0};
    tbl[7]  = '{3, 32'd1, 0, 32'd1, 32'd0, 1'b0, 8'd2, 1'b0, 0};
    tbl[8]  = '{3, 32'd1, 0, 32'd1, 32'd0, 1'b0, 8'd3, 1'b0, 0};
    tbl[9]  = '{3, 32'd1, 0, 32'd1, 32'd0, 1'b0, 8'd1, 1'b0, 0};
    tbl[10] = '{3, 32'd1, 0, 32'd1, 32'd0, 1'b1, 8'd2, 1'b1, 0};
    tbl[11] = '{3, 32'd1, 0, 32'd1, 32'd0, 1'b0, 8'd1, 1'b0, 0};
    tbl[12] = '{3, 32'd1, 0, 32'd1, 32'd0, 1'b0, 8'd2, 1'b0, 0};

    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_bias = '0;
    for (int i = 0; i < 8; i++) sh_bias[i] = 0;
    set_cfg(1, 32'd1, 0);
    repeat (3) tick();
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_m_tdata", 64'(m_tdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sat_count", 64'(sat_count), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();
    chk("idle_s_tready", 64'(s_tready), 64'd1);

    // Single beat: 1024 * 2^30 >> 36 with rounding = 16, four-cycle latency.
    for (int i = 0; i < 8; i++) wr(i, 32'd0, 1'b1);
    wr(0, 32'd24, 1'b1);
    set_cfg(1, 32'h4000_0000, 36);
    send(32'd1000, 1'b1, 8'd16, 1'b1);
    tick(); tick();
    chk("latency_not_yet", 64'(m_tvalid), 64'd0);
    tick();
    chk("latency_valid", 64'(m_tvalid), 64'd1);
    chk("latency_data", 64'(m_tdata), 64'd16);
    drain();

    wr(1, 32'd2, 1'b1);
    wr(2, 32'd3, 1'b1);
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].m3 != cur_m3 || tbl[i].mult != cur_mult || tbl[i].shift != cur_shift ||
          tbl[i].b0 != sh_bias[0]) begin
        drain();
        set_cfg(tbl[i].m3, tbl[i].mult, tbl[i].shift);
        if (tbl[i].b0 != sh_bias[0]) wr(0, tbl[i].b0, 1'b1);
      end
      send(tbl[i].acc, tbl[i].last, tbl[i].exp, tbl[i].explast);
      exp_sat += tbl[i].clip;
    end
    drain();

    // Randomized streams under random backpressure.
    for (int r = 0; r < 4; r++) begin
      rand_ready = 1'b0;
      m_tready = 1'b1;
      drain();
      for (int i = 0; i < 8; i++) wr(i, 32'($signed($urandom_range(0, 2000)) - 1000), 1'b1);
      if (r == 0) set_cfg(int'($urandom_range(1, 8)), 32'($urandom_range(0, 3)), 0);
      else set_cfg(int'($urandom_range(1, 8)), $urandom, int'($urandom_range(28, 63)));
      rand_ready = 1'b1;
      for (int i = 0; i < 120; i++)
        send_model(32'($signed($urandom) >>> $urandom_range(0, 31)), ($urandom_range(0, 7) == 0));
      drain();
    end
    rand_ready = 1'b0;
    m_tready = 1'b1;
    tick();

    // Reset with three beats in flight, then table survival and busy-write rejection.
    set_cfg(3, 32'd1, 0);
    wr(0, 32'd5, 1'b1);
    wr(1, -32'sd7, 1'b1);
    wr(2, 32'd100, 1'b1);
    send_model(32'd10, 1'b0);
    send_model(32'd10, 1'b0);
    send_model(32'd10, 1'b0);
    rst = 1'b1;
    mon_en = 1'b0;
    expq.delete();
    tick(); tick();
    rst = 1'b0;
    mcol = 0;
    exp_sat = 0;
    held = 0;
    mon_en = 1'b1;
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_sat", 64'(sat_count), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_no_valid", 64'(m_tvalid), 64'd0);
    end
    send_model(32'd1, 1'b0);
    chk("busy_during_write", 64'(busy), 64'd1);
    wr(0, 32'd99, 1'b0);
    drain();
    send_model(32'd0, 1'b0);
    send_model(32'd0, 1'b0);
    send_model(32'd0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
